// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: job sequencer for a single FP16 MAC PE.
// Accepts a dot-product job, streams operand reads from the weight and input SRAMs,
// steers the PE accumulate-select/partial-sum inputs, waits out the PE latency and
// returns the captured sum on a valid/ready port. No FP arithmetic is done here.
module pe_seq_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned PE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic [ADDR_W-1:0] cfg_ibase,
  input  logic              cfg_use_psum,
  input  logic [15:0]       cfg_psum,
  output logic              wgt_ren,
  output logic              ipt_ren,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [ADDR_W-1:0] ipt_addr,
  output logic              pe_accum,
  output logic [15:0]       pe_psum,
  input  logic [15:0]       pe_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic              busy
);

  // Drain counter must hold 0..PE_LAT.
  localparam int unsigned DRAIN_W = $clog2(PE_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StHold} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]  wbase_q, wbase_d;
  logic [ADDR_W-1:0]  ibase_q, ibase_d;
  logic [15:0]        seed_q, seed_d;
  logic [15:0]        res_q, res_d;
  logic               accum_q, accum_d;
  logic               issue;

  // Next-state logic: job acceptance, issue/drain counting, result capture and handshake.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    wbase_d = wbase_q;
    ibase_d = ibase_q;
    seed_d  = seed_q;
    res_d   = res_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            len_d   = cfg_len;
            wbase_d = cfg_wbase;
            ibase_d = cfg_ibase;
            seed_d  = cfg_use_psum ? cfg_psum : 16'h0000;
            cnt_d   = '0;
            if (cfg_len == '0) begin
              // Empty job: the result is just the seed.
              res_d   = cfg_use_psum ? cfg_psum : 16'h0000;
              state_d = StHold;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            dcnt_d  = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
        StDrain: begin
          // Last operands land one cycle after the last issue, sum PE_LAT cycles later.
          if (dcnt_q == DRAIN_W'(PE_LAT)) begin
            res_d   = pe_result;
            state_d = StHold;
          end else begin
            dcnt_d = dcnt_q + DRAIN_W'(1);
          end
        end
        StHold: begin
          if (res_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Accumulate-select follows operand arrival: clear only for element 0.
  always_comb begin
    accum_d = !((state_q == StIssue) && (cnt_q == '0) && !abort);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      wbase_q <= '0;
      ibase_q <= '0;
      seed_q  <= 16'h0000;
      res_q   <= 16'h0000;
      accum_q <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      wbase_q <= wbase_d;
      ibase_q <= ibase_d;
      seed_q  <= seed_d;
      res_q   <= res_d;
      accum_q <= accum_d;
    end
  end

  // Outputs decoded from state; addresses wrap modulo 2^ADDR_W.
  always_comb begin
    issue       = (state_q == StIssue);
    start_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    wgt_ren     = issue;
    ipt_ren     = issue;
    wgt_addr    = issue ? wbase_q + ADDR_W'(cnt_q) : '0;
    ipt_addr    = issue ? ibase_q + ADDR_W'(cnt_q) : '0;
    pe_accum    = accum_q;
    pe_psum     = (state_q != StIdle) ? seed_q : 16'h0000;
    res_valid   = (state_q == StHold);
    res_data    = res_q;
  end

endmodule
